// File: rtl/codificador_pkg.sv
// Shared constants and helpers for the parametrised priority encoder.
// Mode selectors and index-width function used by the top and the
// combinational search block.
package codificador_pkg;

  localparam int MODO_FIJO = 0;
  localparam int MODO_RR   = 1;

  // Output index width: never narrower than one bit, even for N = 2.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/codificador_prioridad_comb.sv
// Combinational winner search for the priority encoder.
// Fixed mode picks the highest set bit. Round-robin mode rotates X so the
// search starts at ptr, takes the lowest set bit of the rotated word, and
// maps it back with a modulo-N add (N need not be a power of two).
// Optional build macro: CODIF_MULTIBIT_EN enables the "more than one bit
// set" detector; otherwise multibit is a constant 0.
module codificador_prioridad_comb
  import codificador_pkg::*;
#(
  parameter int N = 8,
  parameter int W = idx_width(N)
) (
  input  logic [N-1:0] X,
  input  logic [W-1:0] ptr,
  input  logic         mode,
  output logic [W-1:0] idx,
  output logic         ninguno,
  output logic         multibit
);

  // Modulo-N add of two indices already below N; one subtraction suffices.
  function automatic logic [W-1:0] wrap_add(input logic [W-1:0] a,
                                            input logic [W-1:0] b);
    logic [W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= (W+1)'(N)) s = s - (W+1)'(N);
    return s[W-1:0];
  endfunction

  logic [N-1:0] rot;
  logic [W-1:0] hi_idx;
  logic [W-1:0] rr_off;

  // Rotate X down by ptr so the round-robin search always starts at bit 0.
  always_comb begin
    rot = '0;
    for (int i = 0; i < N; i++) rot[i] = X[wrap_add(W'(i), ptr)];
  end

  // Highest set bit of X, and lowest set bit of the rotated word.
  always_comb begin
    hi_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (X[i]) hi_idx = W'(i);
    end
    rr_off = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) rr_off = W'(i);
    end
  end

  // Select the mode's winner; an all-zero word reports index 0.
  always_comb begin
    ninguno = (X == '0);
    if (ninguno)   idx = '0;
    else if (mode) idx = wrap_add(rr_off, ptr);
    else           idx = hi_idx;
  end

`ifdef CODIF_MULTIBIT_EN
  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multibit = ((X & (X - N'(1))) != '0);
`else
  assign multibit = 1'b0;
`endif

endmodule

// File: rtl/codificador_prioridad_param.sv
// Parametrised N-to-log2(N) priority encoder with a registered output stage
// and valid/ready handshake on both sides. Fixed-priority or round-robin
// selected by MODO_RR; the round-robin pointer lives here and advances only
// on an accept of a non-zero word.
// Optional build macro: CODIF_MULTIBIT_EN (registers a multi-bit flag).
module codificador_prioridad_param
  import codificador_pkg::*;
#(
  parameter  int N       = 8,
  parameter  int MODO_RR = 0,
  localparam int W       = idx_width(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] X,
  input  logic         valido_in,
  output logic         listo_out,
  output logic [W-1:0] Salida,
  output logic         ninguno,
  output logic         multibit,
  output logic         valido_out,
  input  logic         listo_in
);

  localparam logic MODE_IS_RR = (MODO_RR == codificador_pkg::MODO_RR);

  logic [W-1:0] idx_c;
  logic         ninguno_c;
  logic         multibit_c;
  logic         accept;

  logic [W-1:0] salida_q,   salida_d;
  logic         ninguno_q,  ninguno_d;
  logic         multibit_q, multibit_d;
  logic         valido_q,   valido_d;
  logic [W-1:0] ptr_q,      ptr_d;

  codificador_prioridad_comb #(
    .N (N),
    .W (W)
  ) u_comb (
    .X        (X),
    .ptr      (ptr_q),
    .mode     (MODE_IS_RR),
    .idx      (idx_c),
    .ninguno  (ninguno_c),
    .multibit (multibit_c)
  );

  // Output slot is free when empty or being drained this cycle.
  assign listo_out = !valido_q || listo_in;
  assign accept    = valido_in && listo_out;

  // Next state: load on accept, drop valid on drain, otherwise hold.
  always_comb begin
    salida_d   = salida_q;
    ninguno_d  = ninguno_q;
    multibit_d = multibit_q;
    valido_d   = valido_q;
    ptr_d      = ptr_q;
    if (accept) begin
      salida_d   = idx_c;
      ninguno_d  = ninguno_c;
      multibit_d = multibit_c;
      valido_d   = 1'b1;
      if (MODE_IS_RR && !ninguno_c) begin
        ptr_d = (idx_c == W'(N - 1)) ? '0 : idx_c + W'(1);
      end
    end else if (listo_in) begin
      valido_d = 1'b0;
    end
  end

  // Output register and pointer; reset wins over any accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      salida_q   <= '0;
      ninguno_q  <= 1'b0;
      multibit_q <= 1'b0;
      valido_q   <= 1'b0;
      ptr_q      <= '0;
    end else begin
      salida_q   <= salida_d;
      ninguno_q  <= ninguno_d;
      multibit_q <= multibit_d;
      valido_q   <= valido_d;
      ptr_q      <= ptr_d;
    end
  end

  assign Salida     = salida_q;
  assign ninguno    = ninguno_q;
  assign multibit   = multibit_q;
  assign valido_out = valido_q;

endmodule

// File: doc/codificador_prioridad_param.md
Name: codificador_prioridad_param

Overview:
- Parametrised N-to-log2(N) priority encoder with a registered output stage and a valid/ready handshake on both sides.
- Generalises the fixed 7-to-3 combinational encoder in three ways: configurable width, selectable fixed-priority or round-robin mode, and an explicit "no bit set" flag.
- Sits between request/interrupt sources and downstream decode or arbitration logic. Accepts one input word per handshake and presents one encoded index per handshake.

Parameters:
- N, 8, input vector width; N >= 2.
- W, $clog2(N), output index width; derived, never overridden.
- MODO_RR, 0, 0 = fixed priority (highest set bit wins); 1 = round-robin priority.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, synchronous, active-high.
- X  input  N  request vector.
- valido_in  input  1  X is valid this cycle.
- listo_out  output  1  block can accept X this cycle.
- Salida  output  W  encoded index of the winning bit.
- ninguno  output  1  accepted X was all zeros; Salida is 0 in that case.
- multibit  output  1  accepted X had more than one bit set (see Optional Feature).
- valido_out  output  1  Salida, ninguno and multibit are valid.
- listo_in  input  1  downstream accepts the output this cycle.

Behaviour:
- Single clock, clk. Reset is synchronous and active-high on rst.
- Reset values: valido_out=0, Salida=0, ninguno=0, multibit=0, internal pointer ptr=0.
- Reset mid-transaction discards any held output. No accept occurs in the reset cycle.
- listo_out = !valido_out || listo_in. This is combinational, with no bubble on back-to-back transfers.
- Accept: valido_in && listo_out at a rising edge. Latency is 1 cycle; results appear on the next cycle with valido_out=1.
- Hold: while valido_out && !listo_in, all outputs stay stable and X is ignored (listo_out=0).
- Drain: if listo_in is high and there is no accept in the same cycle, valido_out falls to 0 next cycle.
- Simultaneous accept and drain: new result replaces old one; valido_out stays 1.
- Fixed mode (MODO_RR=0): Salida = index of the highest set bit of X. Example, N=8: X=8'b0010_0110 gives Salida=5.
- Round-robin mode (MODO_RR=1):
  - Search X starting at bit ptr and moving upward, wrapping modulo N. The first set bit wins.
  - On each accept with X!=0: ptr <= (winner+1) mod N. Wrap from N-1 to 0.
  - On accept with X==0, ptr is unchanged. ptr changes only on accept.
- X==0 (either mode): Salida=0, ninguno=1.
- One-hot input (either mode): Salida equals the bit index, matching the legacy 7-to-3 encoding for N=8 with bit 7 unused.
- Arithmetic: all index math is W bits. Modulo wrap is explicit; N need not be a power of two, so wrap at N, not 2^W.

Optional Feature:
- Macro: CODIF_MULTIBIT_EN.
- Defined: multibit is registered on accept, 1 when popcount(X) >= 2, else 0. It is held and reset like Salida.
- Not defined: multibit is tied to 0 and no popcount logic is synthesised. Port list is identical in both builds.

Decomposition:
- Package codificador_pkg holds:
  - constants MODO_FIJO=0 and MODO_RR=1;
  - a function for the index width, max(1, $clog2(N)).
- One combinational sub-module, codificador_prioridad_comb:
  - inputs X, ptr, mode;
  - outputs idx, ninguno, multibit;
  - performs rotate-by-ptr, highest/first-set search, then un-rotate.
- The top level holds the output register, handshake and ptr.

Test Plan:
- Reset then idle: rst=1 for 2 cycles with valido_in=1 -> valido_out=0, Salida=0, ninguno=0, listo_out=1 after release.
- Fixed mode, N=8, listo_in=1: one-hot sweep X=8'h01..8'h80, one per cycle -> Salida=0..7 one cycle later, ninguno=0. Then X=0 -> Salida=0, ninguno=1.
- Fixed mode priority: X=8'b0100_1001 -> Salida=6. With CODIF_MULTIBIT_EN, multibit=1; without it, multibit=0.
- Back-pressure: accept X=8'h10, hold listo_in=0 for 3 cycles while driving X=8'h02 -> Salida stays 4 and listo_out=0. Release listo_in -> 8'h02 accepted, Salida=1 next cycle.
- Round-robin, N=8: X=8'hFF held for 9 accepts -> Salida=0,1,…,7,0, showing ptr wrap. Then X=8'h81 with ptr=1 -> Salida=7, ptr becomes 0.
- Round-robin with N=5 (non power of two): ptr=4, X=5'b10001 -> Salida=4, ptr wraps to 0. Next accept -> Salida=0. Then assert rst mid-hold -> ptr=0 and valido_out=0.
